// File: rtl/complex_tridiag_matvec_v4_if.sv
// Request/result bundle for the complex tridiagonal mat-vec engine.
// The master drives the request side and consumes result groups; the slave is the engine.
interface complex_tridiag_matvec_v4_if #(
    parameter int N_EQN = 3,
    parameter int W     = 64,
    parameter int NU    = 4
);
    logic                         start;
    logic [W*(3*N_EQN-2)-1:0]     mat;
    logic [W*N_EQN-1:0]           vector;
    logic                         out_ready;
    logic                         busy;
    logic [W*NU-1:0]              out;
    logic                         out_valid;
    logic [NU-1:0]                lane_mask;
    logic [15:0]                  out_group;
    logic                         finish;
    logic                         sat_flag;

    modport master (
        output start, mat, vector, out_ready,
        input  busy, out, out_valid, lane_mask, out_group, finish, sat_flag
    );

    modport slave (
        input  start, mat, vector, out_ready,
        output busy, out, out_valid, lane_mask, out_group, finish, sat_flag
    );
endinterface

// File: rtl/complex_tridiag_matvec_v4.sv
// Complex tridiagonal y = A*x engine: NU rows per group through a two-stage
// complex MAC pipeline, Q-format rescale with saturation, valid/ready group output.
module complex_tridiag_matvec_v4 #(
    parameter int N_EQN = 3,
    parameter int W     = 64,
    parameter int NU    = 4,
    parameter int FRAC  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    complex_tridiag_matvec_v4_if.slave    bus
);
    localparam int H  = W / 2;
    localparam int NE = 3 * N_EQN - 2;
    localparam int G  = (N_EQN + NU - 1) / NU;
    localparam int PW = W + 1;
    localparam int AW = W + 2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_ACC  = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-H+1){1'b0}}, {(H-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    // Floor-shift by FRAC, clip to H bits; MSB of the result flags a clip.
    function automatic logic [H:0] scale_sat(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] s;
        s = v >>> FRAC;
        if (s > SAT_MAX)
            return {1'b1, SAT_MAX[H-1:0]};
        else if (s < SAT_MIN)
            return {1'b1, SAT_MIN[H-1:0]};
        return {1'b0, s[H-1:0]};
    endfunction

    logic [2:0]  state;
    logic [15:0] grp;

    logic signed [H-1:0]  m_re_p0 [NE];
    logic signed [H-1:0]  m_im_p0 [NE];
    logic signed [H-1:0]  x_re_p0 [N_EQN];
    logic signed [H-1:0]  x_im_p0 [N_EQN];
    logic signed [PW-1:0] prod_re_c  [NU][3];
    logic signed [PW-1:0] prod_im_c  [NU][3];
    logic signed [PW-1:0] prod_re_p1 [NU][3];
    logic signed [PW-1:0] prod_im_p1 [NU][3];
    logic [NU-1:0]        mask_c;
    logic [W*NU-1:0]      out_c;
    logic                 sat_c;

    // Stage 0: operand capture on the start edge; the run never looks at the live inputs again.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.start) begin
            for (int k = 0; k < NE; k++) begin
                m_re_p0[k] <= bus.mat[W*(k+1)-1 -: H];
                m_im_p0[k] <= bus.mat[W*k +: H];
            end
            for (int j = 0; j < N_EQN; j++) begin
                x_re_p0[j] <= bus.vector[W*(j+1)-1 -: H];
                x_im_p0[j] <= bus.vector[W*j +: H];
            end
        end
    end

    // Row r taps elements 3r-1..3r+1 against x[r-1..r+1]; indices that match nothing read as zero.
    always_comb begin
        int row, e, j;
        logic signed [PW-1:0] ar, ai, xr, xi;
        mask_c = '0;
        for (int l = 0; l < NU; l++) begin
            row = int'(grp) * NU + l;
            mask_c[l] = (row < N_EQN);
            for (int k = 0; k < 3; k++) begin
                e  = 3 * row - 1 + k;
                j  = row - 1 + k;
                ar = '0;
                ai = '0;
                xr = '0;
                xi = '0;
                for (int kk = 0; kk < NE; kk++) begin
                    if (kk == e) begin
                        ar = PW'(m_re_p0[kk]);
                        ai = PW'(m_im_p0[kk]);
                    end
                end
                for (int jj = 0; jj < N_EQN; jj++) begin
                    if (jj == j) begin
                        xr = PW'(x_re_p0[jj]);
                        xi = PW'(x_im_p0[jj]);
                    end
                end
                prod_re_c[l][k] = ar * xr - ai * xi;
                prod_im_c[l][k] = ar * xi + ai * xr;
            end
        end
    end

    // Stage 1: product registers, loaded while in MUL.
    always_ff @(posedge clk) begin
        if (state == S_MUL) begin
            prod_re_p1 <= prod_re_c;
            prod_im_p1 <= prod_im_c;
        end
    end

    always_comb begin
        logic signed [AW-1:0] re_sum, im_sum;
        logic [H:0]           re_q, im_q;
        out_c = '0;
        sat_c = 1'b0;
        for (int l = 0; l < NU; l++) begin
            re_sum = AW'(prod_re_p1[l][0]) + AW'(prod_re_p1[l][1]) + AW'(prod_re_p1[l][2]);
            im_sum = AW'(prod_im_p1[l][0]) + AW'(prod_im_p1[l][1]) + AW'(prod_im_p1[l][2]);
            re_q   = scale_sat(re_sum);
            im_q   = scale_sat(im_sum);
            out_c[W*(l+1)-1 -: W] = {re_q[H-1:0], im_q[H-1:0]};
            sat_c  = sat_c | re_q[H] | im_q[H];
        end
    end

    // Stage 2: output registers and run control.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            grp           <= '0;
            bus.busy      <= 1'b0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.lane_mask <= '0;
            bus.out_group <= '0;
            bus.finish    <= 1'b0;
            bus.sat_flag  <= 1'b0;
        end else begin
            bus.finish <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        grp          <= '0;
                        bus.sat_flag <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= S_MUL;
                    end
                end
                S_MUL: state <= S_ACC;
                S_ACC: begin
                    bus.out       <= out_c;
                    bus.lane_mask <= mask_c;
                    bus.out_group <= grp;
                    bus.out_valid <= 1'b1;
                    bus.sat_flag  <= bus.sat_flag | sat_c;
                    state         <= S_OUT;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (grp < 16'(G - 1)) begin
                            grp   <= grp + 16'd1;
                            state <= S_MUL;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    bus.finish <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_complex_tridiag_matvec_v4.sv
// Directed bench for complex_tridiag_matvec_v4: a 3-row and a 9-row instance, NU=4, Q16.
module tb_complex_tridiag_matvec_v4;
    logic clk;
    logic reset;
    logic start;
    logic out_ready;
    logic sel;
    logic [7*64-1:0]  mat3;
    logic [3*64-1:0]  vec3;
    logic [25*64-1:0] mat9;
    logic [9*64-1:0]  vec9;

    int total;
    int bad;
    int cyc;
    int fin_at;
    int seen;

    logic [255:0] exp_out  [3];
    logic [3:0]   exp_mask [3];

    complex_tridiag_matvec_v4_if #(.N_EQN(3), .W(64), .NU(4)) if3 ();
    complex_tridiag_matvec_v4_if #(.N_EQN(9), .W(64), .NU(4)) if9 ();

    complex_tridiag_matvec_v4 #(.N_EQN(3), .W(64), .NU(4), .FRAC(16)) dut3 (
        .clk(clk), .reset(reset), .bus(if3)
    );
    complex_tridiag_matvec_v4 #(.N_EQN(9), .W(64), .NU(4), .FRAC(16)) dut9 (
        .clk(clk), .reset(reset), .bus(if9)
    );

    assign if3.start     = start & ~sel;
    assign if9.start     = start & sel;
    assign if3.mat       = mat3;
    assign if3.vector    = vec3;
    assign if9.mat       = mat9;
    assign if9.vector    = vec9;
    assign if3.out_ready = out_ready;
    assign if9.out_ready = out_ready;

    logic [255:0] o_out;
    logic         o_valid, o_busy, o_finish, o_sat;
    logic [3:0]   o_mask;
    logic [15:0]  o_group;
    assign o_out    = sel ? if9.out       : if3.out;
    assign o_valid  = sel ? if9.out_valid : if3.out_valid;
    assign o_busy   = sel ? if9.busy      : if3.busy;
    assign o_finish = sel ? if9.finish    : if3.finish;
    assign o_sat    = sel ? if9.sat_flag  : if3.sat_flag;
    assign o_mask   = sel ? if9.lane_mask : if3.lane_mask;
    assign o_group  = sel ? if9.out_group : if3.out_group;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic launch();
        start = 1'b1;
        @(posedge clk);
        #1;
        cyc   = 0;
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!o_valid && n < 60) begin
            tick();
            n++;
        end
        chk({tag, " valid_seen"}, 256'(o_valid), 256'd1);
    endtask

    task automatic wait_finish(input string tag, input int expect_cyc);
        int n;
        n = 0;
        while (!o_finish && n < 60) begin
            tick();
            n++;
        end
        chk({tag, " finish_cycle"}, 256'(cyc), 256'(expect_cyc));
        chk({tag, " busy_at_finish"}, 256'(o_busy), 256'd0);
        tick();
        chk({tag, " finish_pulse_width"}, 256'(o_finish), 256'd0);
    endtask

    task automatic do_groups(input int ng, input int stall_grp, input string tag);
        for (int g = 0; g < ng; g++) begin
            wait_valid($sformatf("%s g%0d", tag, g));
            chk($sformatf("%s g%0d out", tag, g), o_out, exp_out[g]);
            chk($sformatf("%s g%0d mask", tag, g), 256'(o_mask), 256'(exp_mask[g]));
            chk($sformatf("%s g%0d group", tag, g), 256'(o_group), 256'(g));
            if (g == stall_grp) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk($sformatf("%s stall%0d valid", tag, s), 256'(o_valid), 256'd1);
                    chk($sformatf("%s stall%0d out", tag, s), o_out, exp_out[g]);
                    chk($sformatf("%s stall%0d group", tag, s), 256'(o_group), 256'(g));
                    chk($sformatf("%s stall%0d mask", tag, s), 256'(o_mask), 256'(exp_mask[g]));
                end
                out_ready = 1'b1;
            end
            tick();
            chk($sformatf("%s g%0d valid_drop", tag, g), 256'(o_valid), 256'd0);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, " busy"}, 256'(o_busy), 256'd0);
        chk({tag, " out"}, o_out, 256'd0);
        chk({tag, " valid"}, 256'(o_valid), 256'd0);
        chk({tag, " mask"}, 256'(o_mask), 256'd0);
        chk({tag, " group"}, 256'(o_group), 256'd0);
        chk({tag, " finish"}, 256'(o_finish), 256'd0);
        chk({tag, " sat"}, 256'(o_sat), 256'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        sel = 1'b0;
        mat3 = '0;
        vec3 = '0;
        mat9 = '0;
        vec9 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_zero("rst3");
        sel = 1'b1;
        #1;
        check_idle_zero("rst9");
        sel = 1'b0;
        #1;

        // diagonal 1.0, x = {1+2j, 3+4j, 5+6j}; inputs scrambled after capture
        mat3[0*64 +: 64] = 64'h00010000_00000000;
        mat3[3*64 +: 64] = 64'h00010000_00000000;
        mat3[6*64 +: 64] = 64'h00010000_00000000;
        vec3 = {64'h00050000_00060000, 64'h00030000_00040000, 64'h00010000_00020000};
        exp_out[0]  = {64'd0, 64'h00050000_00060000, 64'h00030000_00040000, 64'h00010000_00020000};
        exp_mask[0] = 4'b0111;
        launch();
        chk("t1 busy_rise", 256'(o_busy), 256'd1);
        mat3 = '1;
        vec3 = '1;
        do_groups(1, -1, "t1");
        wait_finish("t1", 4);

        // all taps j, x = {1, 2, 3} -> y = {3j, 6j, 5j}
        for (int k = 0; k < 7; k++) mat3[k*64 +: 64] = 64'h00000000_00010000;
        vec3 = {64'h00030000_00000000, 64'h00020000_00000000, 64'h00010000_00000000};
        exp_out[0] = {64'd0, 64'h00000000_00050000, 64'h00000000_00060000, 64'h00000000_00030000};
        launch();
        do_groups(1, -1, "t2");
        wait_finish("t2", 4);
        chk("t2 sat_clear", 256'(o_sat), 256'd0);

        // 32767.0 * 4.0 overflows Q16.16 -> clip to max positive
        mat3 = '0;
        mat3[0*64 +: 64] = 64'h7FFF0000_00000000;
        vec3 = {64'd0, 64'd0, 64'h00040000_00000000};
        exp_out[0] = {192'd0, 64'h7FFFFFFF_00000000};
        launch();
        do_groups(1, -1, "t5");
        chk("t5 sat_set", 256'(o_sat), 256'd1);
        wait_finish("t5", 4);
        tick();
        chk("t5 sat_hold", 256'(o_sat), 256'd1);

        mat3 = '0;
        mat3[3*64 +: 64] = 64'h00010000_00000000;
        vec3 = {64'd0, 64'h00030000_00040000, 64'd0};
        exp_out[0] = {128'd0, 64'h00030000_00040000, 64'd0};
        launch();
        chk("t5b sat_cleared_on_capture", 256'(o_sat), 256'd0);
        do_groups(1, -1, "t5b");
        wait_finish("t5b", 4);
        chk("t5b sat_stays_clear", 256'(o_sat), 256'd0);

        // identity 9x9, x_i = (i+1) - j(i+1)
        sel = 1'b1;
        #1;
        for (int i = 0; i < 9; i++) begin
            mat9[3*i*64 +: 64] = 64'h00010000_00000000;
            vec9[i*64 +: 64]   = {32'((i + 1) * 65536), 32'(-(i + 1) * 65536)};
        end
        for (int g = 0; g < 3; g++) begin
            exp_out[g]  = '0;
            exp_mask[g] = '0;
            for (int l = 0; l < 4; l++) begin
                if (g * 4 + l < 9) begin
                    exp_out[g][l*64 +: 64] = vec9[(g*4+l)*64 +: 64];
                    exp_mask[g][l] = 1'b1;
                end
            end
        end
        launch();
        do_groups(3, -1, "t3");
        wait_finish("t3", 10);

        launch();
        do_groups(3, 1, "t4");
        wait_finish("t4", 15);

        // reset while group 1 is presented
        launch();
        wait_valid("t6 g0");
        tick();
        wait_valid("t6 g1");
        chk("t6 g1 group", 256'(o_group), 256'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_zero("t6 after_reset");
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_finish || o_valid) seen++;
        end
        chk("t6 no_activity_after_reset", 256'(seen), 256'd0);
        launch();
        do_groups(3, -1, "t6 rerun");
        wait_finish("t6 rerun", 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
